// File: rtl/data_mem_sequencer_pkg.sv
// Shared decode types: cuOPType encoding, memory-access helpers and sequencer state enum.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package data_mem_sequencer_pkg;

  // Memory ops occupy one contiguous range so isMem is a simple range compare.
  typedef enum logic [5:0] {
    CU_ERROR = 6'd0,
    CU_ADD   = 6'd1,
    CU_SUB   = 6'd2,
    CU_AND   = 6'd3,
    CU_OR    = 6'd4,
    CU_XOR   = 6'd5,
    CU_LB    = 6'd16,
    CU_LH    = 6'd17,
    CU_LW    = 6'd18,
    CU_LBU   = 6'd19,
    CU_LHU   = 6'd20,
    CU_SB    = 6'd21,
    CU_SH    = 6'd22,
    CU_SW    = 6'd23
  } cuOPType;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_BUSY,
    MS_DONE
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } mem_size_e;

  function automatic logic isMem(input logic [5:0] op);
    return (op >= CU_LB) && (op <= CU_SW);
  endfunction

  function automatic logic isLoad(input logic [5:0] op);
    return (op >= CU_LB) && (op <= CU_LHU);
  endfunction

  function automatic logic isStore(input logic [5:0] op);
    return (op >= CU_SB) && (op <= CU_SW);
  endfunction

  // Non-memory ops fall through to word size; callers only use this for memory ops.
  function automatic mem_size_e mem_size(input logic [5:0] op);
    case (op)
      CU_LB, CU_LBU, CU_SB: return SZ_BYTE;
      CU_LH, CU_LHU, CU_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_sequencer_if.sv
// Data-memory bus between the sequencer (master) and memory (slave).
// Latency: n/a (wires only).
// Backpressure: master holds ren/wen and address/data until mem_ready.
interface data_mem_sequencer_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic        mem_ren;
  logic        mem_wen;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_sel, mem_ren, mem_wen,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_sel, mem_ren, mem_wen,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/data_mem_sequencer_byte_lane_gen.sv
// Byte-lane generator: op + address + store data -> byte enables, replicated wdata, aligned address.
// Latency: combinational.
// Backpressure: none. Misalign detection only under MISALIGN_TRAP_EN, else force-align and flag 0.
module byte_lane_gen
  import data_mem_sequencer_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] addr_aligned,
  output logic [31:0] wdata,
  output logic [3:0]  sel,
  output logic        misaligned
);

  mem_size_e size;
  assign size = mem_size(op);

  // Lane selection and write-data replication by access width.
  always_comb begin
    addr_aligned = addr;
    wdata        = store_data;
    sel          = 4'b1111;
    case (size)
      SZ_BYTE: begin
        sel   = 4'b0001 << addr[1:0];
        wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        addr_aligned[0] = 1'b0;
        sel             = 4'b0011 << {addr[1], 1'b0};
        wdata           = {2{store_data[15:0]}};
      end
      default: begin
        addr_aligned[1:0] = 2'b00;
        sel               = 4'b1111;
        wdata             = store_data;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((size == SZ_HALF) && addr[0]) ||
                      ((size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/data_mem_sequencer.sv
// Load/store sequencer: issues one ready-acknowledged bus access per memory cuOP and stalls the PC meanwhile.
// Latency: 3 cycles minimum (IDLE, BUSY, DONE); BUSY lasts until mem_ready or TIMEOUT_CYCLES.
// Backpressure: request held stable while mem_ready is low; stall high in IDLE(mem op) and BUSY. Option: MISALIGN_TRAP_EN.
module data_mem_sequencer
  import data_mem_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic        clk,
  input  logic        nRst,
  input  logic [5:0]  cuOP,
  input  logic [31:0] aluOut,
  input  logic [31:0] storeData,
  data_mem_sequencer_if.master bus,
  output logic [31:0] memload,
  output logic        stall,
  output logic        bus_err,
  output logic        misalign
);

  mem_state_e  state, state_nxt;
  logic [7:0]  cnt;
  logic        load_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  sel_q;
  logic        ren_q, wen_q;
  logic [31:0] lane_addr, lane_wdata;
  logic [3:0]  lane_sel;
  logic        lane_misaligned;
  logic        start, complete, timeout, trap;

  byte_lane_gen u_lane (
    .op           (cuOP),
    .addr         (aluOut),
    .store_data   (storeData),
    .addr_aligned (lane_addr),
    .wdata        (lane_wdata),
    .sel          (lane_sel),
    .misaligned   (lane_misaligned)
  );

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_sel   = sel_q;
  assign bus.mem_ren   = ren_q;
  assign bus.mem_wen   = wen_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!nRst) state <= MS_IDLE;
    else       state <= state_nxt;
  end

  // Next state, event strobes and PC stall.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    trap      = 1'b0;
    case (state)
      MS_IDLE: begin
        if (isMem(cuOP)) begin
          if (lane_misaligned) begin
            trap      = 1'b1;
            state_nxt = MS_DONE;
          end else begin
            start     = 1'b1;
            state_nxt = MS_BUSY;
          end
        end
      end
      MS_BUSY: begin
        if (bus.mem_ready) begin
          complete  = 1'b1;
          state_nxt = MS_DONE;
        end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          timeout   = 1'b1;
          state_nxt = MS_DONE;
        end
      end
      MS_DONE: state_nxt = MS_IDLE;
      default: state_nxt = MS_IDLE;
    endcase
    stall = ((state == MS_IDLE) && isMem(cuOP)) || (state == MS_BUSY);
  end

  // Request latch, memload capture and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      load_q   <= 1'b0;
      memload  <= '0;
      bus_err  <= 1'b0;
      misalign <= 1'b0;
    end else begin
      bus_err  <= timeout;
      misalign <= trap;
      if (start) begin
        addr_q  <= lane_addr;
        wdata_q <= lane_wdata;
        sel_q   <= lane_sel;
        ren_q   <= isLoad(cuOP);
        wen_q   <= !isLoad(cuOP);
        load_q  <= isLoad(cuOP);
      end
      if (complete || timeout) begin
        ren_q <= 1'b0;
        wen_q <= 1'b0;
      end
      if (complete && load_q) memload <= bus.mem_rdata >> {addr_q[1:0], 3'b000};
      if (timeout || trap)    memload <= '0;
    end
  end

  // BUSY-cycle counter; cleared whenever the sequencer is not waiting.
  always_ff @(posedge clk) begin
    if (!nRst)                                          cnt <= '0;
    else if (state == MS_BUSY && !complete && !timeout) cnt <= cnt + 8'd1;
    else                                                cnt <= '0;
  end

endmodule
